// File: rtl/pg_operand_stage_pkg.sv
// Shared ALU definitions for the adder operand path.
// Contents: opcode encodings seen on in_op, and the depth of the
// operand-stage result FIFO.
package pg_operand_stage_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_ADC = 2'b10;
  localparam alu_op_t OP_INC = 2'b11;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/pg_operand_stage_pg_gen_4.sv
// pg_gen_4: 4-bit propagate/generate slice, one per lookahead nibble group.
// Ports:
//   a  in  4  operand A bits
//   b  in  4  conditioned operand B bits
//   p  out 4  propagate, a ^ b
//   g  out 4  generate,  a & b
module pg_gen_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p,
  output logic [3:0] g
);

  assign p = a ^ b;
  assign g = a & b;

endmodule

// File: rtl/pg_operand_stage.sv
// pg_operand_stage: registered operand front-end for the ALU adder path.
// Conditions operand B and the carry-in per opcode, forms per-bit
// propagate/generate, and buffers results in a 2-entry in-order FIFO ahead
// of the carry-lookahead stage. WIDTH must be a multiple of 4.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_a, in_b        operands
//   in_op             00 ADD, 01 SUB, 10 ADC, 11 INC
//   in_cin            carry-in, only used by ADC
//   out_valid/ready   downstream handshake
//   out_p, out_g      propagate / generate of the head entry
//   out_c0            lookahead carry-in of the head entry
module pg_operand_stage
  import pg_operand_stage_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g,
  output logic             out_c0
);

  logic [WIDTH-1:0] b_cond;
  logic             c0_cond;
  logic [WIDTH-1:0] p_new;
  logic [WIDTH-1:0] g_new;

  logic [WIDTH-1:0] p_mem  [FIFO_DEPTH];
  logic [WIDTH-1:0] g_mem  [FIFO_DEPTH];
  logic             c0_mem [FIFO_DEPTH];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       push;
  logic       pop;

  // Subtraction is a + ~b + 1; increment is a + 0 + 1.
  always_comb begin
    b_cond  = in_b;
    c0_cond = 1'b0;
    case (in_op)
      OP_SUB: begin
        b_cond  = ~in_b;
        c0_cond = 1'b1;
      end
      OP_ADC: c0_cond = in_cin;
      OP_INC: begin
        b_cond  = '0;
        c0_cond = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH / 4; i++) begin : g_slice
    pg_gen_4 u_pg (
      .a (in_a[4*i +: 4]),
      .b (b_cond[4*i +: 4]),
      .p (p_new[4*i +: 4]),
      .g (g_new[4*i +: 4])
    );
  end

  assign push      = in_valid && in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: ;
    endcase
  end

  // in_ready is registered from count_next so out_ready never reaches it
  // combinationally; a pop frees a slot one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next < 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        p_mem[i]  <= '0;
        g_mem[i]  <= '0;
        c0_mem[i] <= 1'b0;
      end
    end else if (push) begin
      p_mem[wr_ptr]  <= p_new;
      g_mem[wr_ptr]  <= g_new;
      c0_mem[wr_ptr] <= c0_cond;
    end
  end

  assign out_p  = p_mem[rd_ptr];
  assign out_g  = g_mem[rd_ptr];
  assign out_c0 = c0_mem[rd_ptr];

endmodule

// File: tb/tb_pg_operand_stage.sv
module tb_pg_operand_stage;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        cin;
    logic [15:0] p;
    logic [15:0] g;
    logic        c0;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_op;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [15:0] out_g;
  logic        out_c0;

  int n_cmp = 0;
  int n_err = 0;

  vec_t vecs[8];
  vec_t bp[3];

  pg_operand_stage #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_g     (out_g),
    .out_c0    (out_c0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_a   = v.a;
    in_b   = v.b;
    in_op  = v.op;
    in_cin = v.cin;
  endtask

  task automatic chk_out(input string name, input vec_t v);
    chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    chk({name, " out_p"},     32'(out_p),     32'(v.p));
    chk({name, " out_g"},     32'(out_g),     32'(v.g));
    chk({name, " out_c0"},    32'(out_c0),    32'(v.c0));
  endtask

  initial begin
    //            a        b        op     cin   p        g        c0
    vecs[0] = '{16'h00FF, 16'h0001, 2'b00, 1'b0, 16'h00FE, 16'h0001, 1'b0};
    vecs[1] = '{16'h0005, 16'h0003, 2'b01, 1'b0, 16'hFFF9, 16'h0004, 1'b1};
    vecs[2] = '{16'h1234, 16'hFFFF, 2'b11, 1'b0, 16'h1234, 16'h0000, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 2'b10, 1'b1, 16'h0000, 16'h8000, 1'b1};
    vecs[4] = '{16'hF0F0, 16'h0FF0, 2'b10, 1'b0, 16'hFF00, 16'h00F0, 1'b0};
    vecs[5] = '{16'hAAAA, 16'h5555, 2'b00, 1'b1, 16'hFFFF, 16'h0000, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 2'b01, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
    vecs[7] = '{16'h0000, 16'h1234, 2'b11, 1'b1, 16'h0000, 16'h0000, 1'b1};

    bp[0] = '{16'h1111, 16'h0000, 2'b00, 1'b0, 16'h1111, 16'h0000, 1'b0};
    bp[1] = '{16'h0000, 16'h0000, 2'b01, 1'b0, 16'hFFFF, 16'h0000, 1'b1};
    bp[2] = '{16'h00F0, 16'h0F00, 2'b10, 1'b1, 16'h0FF0, 16'h0000, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'b00;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst in_ready",  32'(in_ready),  32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_p",     32'(out_p),     32'd0);
    chk("rst out_g",     32'(out_g),     32'd0);
    chk("rst out_c0",    32'(out_c0),    32'd0);
    rst = 1'b0;
    #2;
    chk("release in_ready before edge", 32'(in_ready), 32'd0);
    step();
    chk("release in_ready after edge", 32'(in_ready), 32'd1);

    // Single ops from the table, one at a time
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("vec%0d pre out_valid", i), 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      chk_out($sformatf("vec%0d", i), vecs[i]);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
    end

    // Back-pressure: three back-to-back ops with out_ready low
    out_ready = 1'b0;
    drive(bp[0]);
    in_valid = 1'b1;
    chk("bp in_ready 0", 32'(in_ready), 32'd1);
    step();
    drive(bp[1]);
    chk("bp in_ready 1", 32'(in_ready), 32'd1);
    chk_out("bp head after 1", bp[0]);
    step();
    drive(bp[2]);
    chk("bp full in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("bp hold%0d", k), bp[0]);
      chk($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk_out("bp out1", bp[1]);
    chk("bp in_ready after pop", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk_out("bp out2", bp[2]);
    step();
    chk("bp empty", 32'(out_valid), 32'd0);

    // Streaming: 8 consecutive ops with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      if (i > 0) chk_out($sformatf("stream%0d", i - 1), vecs[i-1]);
      step();
    end
    in_valid = 1'b0;
    chk_out("stream7", vecs[7]);
    chk("stream in_ready end", 32'(in_ready), 32'd1);
    step();
    chk("stream empty", 32'(out_valid), 32'd0);

    // Reset pulsed with two entries buffered
    out_ready = 1'b0;
    drive(vecs[3]);
    in_valid = 1'b1;
    step();
    drive(vecs[4]);
    step();
    chk("pre-rst full in_ready", 32'(in_ready), 32'd0);
    chk_out("pre-rst head", vecs[3]);
    drive(vecs[5]);
    rst = 1'b1;
    #1;
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst in_ready",  32'(in_ready),  32'd0);
    chk("mid-rst out_p",     32'(out_p),     32'd0);
    step();
    chk("rst edge out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post-rst in_ready",  32'(in_ready),  32'd1);
    chk("post-rst out_valid", 32'(out_valid), 32'd0);
    drive(vecs[6]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_out("post-rst op", vecs[6]);
    out_ready = 1'b1;
    step();
    chk("post-rst drained", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pg_operand_stage.md
# pg_operand_stage

Registered operand front-end for the ALU adder path. It accepts operand pairs and an opcode over a valid/ready handshake, conditions the B operand and the carry-in per opcode, and forms per-bit propagate and generate vectors. It buffers the results in a 2-entry in-order FIFO and presents `p`, `g` and `c_0` to the downstream carry-lookahead stage over a second valid/ready handshake. It is the stage directly upstream of the carry-lookahead units and decouples operand arrival from lookahead/sum back-pressure.

## Interface
- `WIDTH`, default 16: operand width; must be a multiple of 4 (nibble groups for lookahead).
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: upstream offers an operation.
- `in_ready`  out  1: stage can accept; transfer when `in_valid && in_ready`.
- `in_a`  in  WIDTH: operand A.
- `in_b`  in  WIDTH: operand B.
- `in_op`  in  2: 00 ADD, 01 SUB, 10 ADC, 11 INC.
- `in_cin`  in  1: carry-in, used only by ADC.
- `out_valid`  out  1: head entry valid.
- `out_ready`  in  1: downstream consumes; pop when `out_valid && out_ready`.
- `out_p`  out  WIDTH: propagate, `a ^ b'`.
- `out_g`  out  WIDTH: generate, `a & b'`.
- `out_c0`  out  1: lookahead carry-in.

## Operation
- Operand conditioning at capture:
  - ADD: `b' = b`, `c0 = 0`.
  - SUB: `b' = ~b`, `c0 = 1`.
  - ADC: `b' = b`, `c0 = in_cin`.
  - INC: `b' = 0`, `c0 = 1`, and `in_b` is ignored.
- Conditioned `p`, `g` and `c0` are computed combinationally from inputs and written into the FIFO on the accept edge. Raw operands are not stored.
- FIFO: 2 entries, circular write/read pointers (1 bit each, wrap 1→0), plus a 2-bit `count` in the range 0..2.
  - Push only: `count+1`.
  - Pop only: `count-1`.
  - Push and pop in the same cycle: `count` unchanged, both pointers advance.
  - Push at `count==2` cannot happen because `in_ready` is low.
  - Pop at `count==0` cannot happen because `out_valid` is low.
- `out_valid = (count != 0)`.
- Outputs are driven from the entry at the read pointer. They hold stable while `out_valid && !out_ready`.
- `in_ready` is a flop: reset 0; at each clock edge it loads `(count_next < 2)`.
- Ordering is strict FIFO; no entry is dropped or duplicated.

## Timing
- Reset values:
  - `in_ready=0`, `out_valid=0`, `count=0`, pointers 0.
  - `out_p`, `out_g` and `out_c0` are 0, with storage cleared.
- `in_ready` rises on the first clock edge after `rst` deasserts.
- Latency: with the FIFO empty, an op accepted at edge N shows `out_valid=1` with its data after edge N, so it is consumable at edge N+1.
- Throughput: 1 op/cycle sustained whenever `out_ready=1`.
- Back-pressure: with `out_ready=0`, two ops are accepted. `in_ready` falls after the second accept edge. It rises again after the edge following the first pop.
- Reset mid-operation: asserting `rst` immediately clears `out_valid`, `in_ready` and `count`. Buffered ops are discarded, and no partial transfer completes on that edge.
- `in_*` are sampled only on accept edges. `out_ready` is not combinationally coupled to `in_ready`, so there is no ready path from output to input.

## Structure
- Shared ALU package holds:
  - opcode localparams `OP_ADD=2'b00`, `OP_SUB=2'b01`, `OP_ADC=2'b10`, `OP_INC=2'b11`;
  - FIFO depth constant 2.
- One natural sub-module, `pg_gen_4`: 4-bit slice taking `a[3:0]`, `b'[3:0]` and outputting `p[3:0]`, `g[3:0]`. It is instantiated `WIDTH/4` times.
- Conditioning mux and FIFO live in the top level.

## Test plan
- Reset release: check `in_ready=0`, `out_valid=0` and all data 0 during `rst`; `in_ready=1` after the first clock edge following deassertion.
- ADD `a=0x00FF`, `b=0x0001` → `p=0x00FE`, `g=0x0001`, `c0=0`, `out_valid` one edge after accept.
- SUB `a=0x0005`, `b=0x0003` → `p=0xFFF9`, `g=0x0004`, `c0=1`. INC `a=0x1234`, `b=0xFFFF` → `p=0x1234`, `g=0x0000`, `c0=1`. ADC `a=0x8000`, `b=0x8000`, `cin=1` → `p=0x0000`, `g=0x8000`, `c0=1`.
- Back-pressure with `out_ready=0`, three back-to-back ops:
  - first two are accepted and the third is held with `in_ready=0`;
  - outputs are stable for 5 cycles;
  - after `out_ready=1`, all three emerge in order with no gaps after the first.
- Streaming with `out_ready=1` and 8 consecutive ops: one output per cycle, `count` never exceeds 1, and the simultaneous push/pop path is exercised.
- `rst` pulsed with 2 entries buffered: `out_valid` drops at once; after release no stale entry appears and the next op emerges with correct values.
